// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with synchronous
// active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; clear drives both to 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw input, requires 2^WIDTH
// consecutive cycles of a new level before accepting it, and emits
// one-cycle press/release strobes alongside the clean level.
module button_debouncer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic PushButton,
  output logic PB_state,
  output logic PB_down,
  output logic PB_up
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             sync;
  logic [WIDTH-1:0] cnt;
  logic             idle;
  logic             cnt_done;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d   (PushButton),
    .q   (sync)
  );

  // Idle when the synchronized input agrees with the accepted level.
  always_comb begin
    idle     = (sync == PB_state);
    cnt_done = (cnt == CNT_MAX);
  end

  // Stability counter, accepted level and registered strobes.
  // The counter wraps to 0 naturally on the toggle edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt      <= '0;
      PB_state <= 1'b0;
      PB_down  <= 1'b0;
      PB_up    <= 1'b0;
    end else begin
      PB_down <= 1'b0;
      PB_up   <= 1'b0;
      if (idle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
        if (cnt_done) begin
          PB_state <= ~PB_state;
          PB_down  <= ~PB_state;
          PB_up    <= PB_state;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer at WIDTH=4 (18-cycle latency): a table of
// timed input segments with hand-derived results, a cycle-exact latency
// sequence, and random segments checked every cycle against a reference
// model.
module tb_button_debouncer;

  localparam int unsigned W        = 4;
  localparam int unsigned INTERVAL = 1 << W;
  localparam int unsigned LATENCY  = INTERVAL + 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic pb  = 1'b0;
  logic PB_state, PB_down, PB_up;

  int total = 0;
  int bad   = 0;

  button_debouncer #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .PushButton (pb),
    .PB_state   (PB_state),
    .PB_down    (PB_down),
    .PB_up      (PB_up)
  );

  always #10 clk = ~clk;

  // Reference model: two-stage input delay, then a record of the
  // synchronized samples seen since the last agreement with the level.
  // The level flips once that record holds INTERVAL disagreeing samples.
  bit m_p1, m_p2, m_st, m_dn, m_up;
  bit mism_q[$];

  always @(posedge clk) begin
    if (clr) begin
      m_p1 = 0; m_p2 = 0; m_st = 0; m_dn = 0; m_up = 0;
      mism_q.delete();
    end else begin
      m_dn = 0;
      m_up = 0;
      if (m_p2 != m_st) mism_q.push_back(m_p2);
      else              mism_q.delete();
      if (mism_q.size() == INTERVAL) begin
        m_st = !m_st;
        if (m_st) m_dn = 1; else m_up = 1;
        mism_q.delete();
      end
      m_p2 = m_p1;
      m_p1 = pb;
    end
  end

  // Strobe tallies, sampled just after each edge.
  int downs = 0;
  int ups   = 0;
  always @(posedge clk) begin
    #1;
    if (PB_down === 1'b1) downs++;
    if (PB_up === 1'b1)   ups++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    total++;
    if ({PB_state, PB_down, PB_up} !== {m_st, m_dn, m_up}) begin
      bad++;
      $display("FAIL model t=%0t got st/dn/up=%b%b%b want %b%b%b",
               $time, PB_state, PB_down, PB_up, m_st, m_dn, m_up);
    end
    total++;
    if (PB_down === 1'b1 && PB_up === 1'b1) begin
      bad++;
      $display("FAIL strobe_overlap t=%0t got dn=1 up=1 want not both", $time);
    end
  end

  typedef struct {
    bit clr;
    bit pb;
    int cycles;
    bit st;
    int dn;
    int up;
  } seg_t;

  seg_t tbl[$];
  int   d0, u0, n;
  bit   found;

  task automatic add(input bit c, input bit p, input int cy,
                     input bit s, input int d, input int u);
    seg_t e;
    e.clr = c; e.pb = p; e.cycles = cy; e.st = s; e.dn = d; e.up = u;
    tbl.push_back(e);
  endtask

  initial begin
    // reset held with button pressed, then fresh count after release
    add(1, 1, 5,  0, 0, 0);
    add(0, 1, 17, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0);
    add(0, 1, 30, 1, 0, 0);
    // release: symmetric latency
    add(0, 0, 17, 1, 0, 0);
    add(0, 0, 1,  0, 0, 1);
    // bounce: 10 high, 1 low, then steady high
    add(0, 1, 10, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0);
    add(0, 1, 17, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0);
    // 15-cycle release glitches are rejected
    add(0, 0, 15, 1, 0, 0);
    add(0, 1, 5,  1, 0, 0);
    add(0, 0, 15, 1, 0, 0);
    add(0, 1, 5,  1, 0, 0);
    // reset mid-count discards the count without a strobe
    add(0, 0, 10, 1, 0, 0);
    add(1, 1, 1,  0, 0, 0);
    add(0, 1, 17, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      clr = tbl[i].clr;
      pb  = tbl[i].pb;
      d0  = downs;
      u0  = ups;
      repeat (tbl[i].cycles - 1) @(negedge clk);
      @(posedge clk);
      #2;
      total++;
      if (PB_state !== tbl[i].st || downs - d0 != tbl[i].dn || ups - u0 != tbl[i].up) begin
        bad++;
        $display("FAIL vec%0d got st=%b dn=%0d up=%0d want st=%b dn=%0d up=%0d",
                 i, PB_state, downs - d0, ups - u0, tbl[i].st, tbl[i].dn, tbl[i].up);
      end
    end

    // Cycle-exact release then press, each strobe one cycle wide.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pb = (k == 1);
      n = 0;
      found = 0;
      while (n < 40 && !found) begin
        @(posedge clk);
        #1;
        n++;
        if ((k == 0 && PB_up === 1'b1) || (k == 1 && PB_down === 1'b1)) found = 1;
      end
      total++;
      if (!found || n != LATENCY) begin
        bad++;
        $display("FAIL latency%0d got edge=%0d found=%0d want edge=%0d", k, n, found, LATENCY);
      end
      @(posedge clk);
      #1;
      total++;
      if (PB_down !== 1'b0 || PB_up !== 1'b0) begin
        bad++;
        $display("FAIL strobe_width%0d got dn=%b up=%b want 0 0", k, PB_down, PB_up);
      end
    end

    // Random segments, checked per cycle by the model.
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 19) == 0);
      pb  = $urandom_range(0, 1);
      repeat ($urandom_range(1, 24) - 1) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
